alu_serie: RTL and testbench
============================

// Module: alu_serie
// PURPOSE
//  Bit-serial arithmetic-logic unit. Drives a single 1-bit arithmetic-logic cell
//  for WIDTH consecutive cycles, LSB first, and feeds the carry back through a register.
//  Latches the operands and control on start, then shifts the result in bit by bit.
//  Presents the full word with flags and a one-cycle done pulse.
//  Sits between the practice datapath registers and the cal cell. It trades
//  WIDTH cycles of latency for one cell instead of WIDTH cells.
// PARAMETERS
//  WIDTH   8   operand/result width in bits (>=2)
// PORTS
//  clk     in   1      single clock, rising edge
//  reset   in   1      synchronous, active-high
//  start   in   1      request; sampled only in IDLE
//  a       in   WIDTH  operand A, latched on accepted start
//  b       in   WIDTH  operand B, latched on accepted start
//  l       in   1      1=logic op, 0=add; latched on accepted start
//  s       in   2      logic function select, passed unmodified to the cell; latched
//  c_in    in   1      initial carry for add; latched
//  result  out  WIDTH  result word; holds its value until the next accepted start
//  c_out   out  1      final carry (add only; 0 when l=1)
//  zero    out  1      result==0, registered at completion
//  busy    out  1      high while the serial operation runs
//  done    out  1      one-cycle pulse: result/flags valid
// BEHAVIOUR
//  - Clock/reset: one clock, clk. reset is synchronous and active-high. Reset has
//    priority over all other inputs, including mid-operation.
//  - Reset values: state=IDLE, result=0, c_out=0, zero=0, busy=0, done=0,
//    count=0, carry reg=0.
//  - FSM IDLE -> RUN -> DONE -> IDLE:
//    IDLE: start=1 loads sh_a<=a, sh_b<=b, l/s regs, carry<=c_in, count<=0,
//          result<=0, then goes to RUN. start=0 stays in IDLE.
//    RUN:  busy=1. Cell inputs: a=sh_a[0], b=sh_b[0], c_in=carry, plus the latched l/s.
//          Each cycle: result<={cell.out, result[WIDTH-1:1]}; carry<=cell.c_out;
//          sh_a/sh_b shift right; count++. When count==WIDTH-1, go to DONE.
//    DONE: done=1 and busy=0 for exactly one cycle. c_out<=(l?0:carry);
//          zero<=(result==0). Always returns to IDLE. start is ignored here.
//  - start while in RUN or DONE: ignored, no queueing. Input changes after
//    acceptance do not affect the operation in flight.
//  - Latency: start accepted at edge N -> done high in the cycle after edge N+WIDTH+1.
//    Next start is accepted in IDLE, one cycle after done at the earliest.
//  - Arithmetic: modulo 2^WIDTH. Carry out of the MSB goes only to c_out; no overflow flag.
//  - Logic mode: carry still chains internally, but it is not reported.
//  - Reset mid-RUN: operation aborted, all outputs return to reset values, and no done pulse.
// STRUCTURE
//  - Shared include (alu_serie_defs.vh): state encodings IDLE=2'd0, RUN=2'd1,
//    DONE=2'd2; default WIDTH.
//  - One sub-module instance: cal (1-bit arithmetic-logic cell). All sequencing,
//    shift registers, counter ($clog2(WIDTH) bits) and flags live in this module.
// TESTING
//  1. a=8'h5A, b=8'h33, l=0, c_in=0, start pulse -> done 9 cycles later,
//     result=8'h8D, c_out=0, zero=0.
//  2. a=8'hFF, b=8'h01, l=0, c_in=0 -> result=8'h00, c_out=1, zero=1.
//  3. a=8'h10, b=8'h20, l=0, c_in=1 -> result=8'h31, c_out=0.
//  4. start held high through RUN with changing a/b -> exactly one done and result of
//     the first operands. A start pulse in the DONE cycle -> ignored.
//  5. reset at RUN cycle 4 -> next cycle busy=0, result=0, no done. A fresh start
//     with 8'h01+8'h01 -> 8'h02.
//  6. l=1, all four s values, a=8'hC5, b=8'h3A -> result bitwise-equal to the
//     cell's per-bit logic function; c_out=0.

Source files
------------

// File: rtl/alu_serie_pkg.sv
// Shared definitions for the bit-serial ALU: FSM states, default width,
// and the per-bit logic function used by the cell.
package alu_serie_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Per-bit logic function selected by s: 00=AND, 01=OR, 10=XOR, 11=XNOR
   function automatic logic cal_logic(input logic a, input logic b, input logic [1:0] s);
      logic r;
      case (s)
         2'b00:   r = a & b;
         2'b01:   r = a | b;
         2'b10:   r = a ^ b;
         default: r = ~(a ^ b);
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_serie_cal.sv
// One-bit arithmetic-logic cell: full adder when l=0, bitwise function when l=1.
// The carry output is always the full-adder carry so it can chain in either mode.
module alu_serie_cal
   import alu_serie_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic       c_in,
   input  logic       l,
   input  logic [1:0] s,
   output logic       out,
   output logic       c_out
);

   // Combinational cell function
   always_comb begin
      out   = l ? cal_logic(a, b, s) : (a ^ b ^ c_in);
      c_out = (a & b) | (c_in & (a ^ b));
   end

endmodule

// File: rtl/alu_serie.sv
// Bit-serial ALU: runs one cal cell for WIDTH cycles LSB first, carry fed back
// through a register, result shifted in from the top.
module alu_serie
   import alu_serie_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             l,
   input  logic [1:0]       s,
   input  logic             c_in,
   output logic [WIDTH-1:0] result,
   output logic             c_out,
   output logic             zero,
   output logic             busy,
   output logic             done
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic             l_reg;
   logic [1:0]       s_reg;
   logic             carry;
   logic [CNT_W-1:0] count;
   logic             cell_out;
   logic             cell_c_out;

   alu_serie_cal cal (
      .a     (sh_a[0]),
      .b     (sh_b[0]),
      .c_in  (carry),
      .l     (l_reg),
      .s     (s_reg),
      .out   (cell_out),
      .c_out (cell_c_out)
   );

   // Sequencer: latch on start, shift WIDTH bits, then publish flags with a done pulse.
   // done is registered while leaving DONE, so the pulse lands in IDLE; start is
   // refused during that pulse cycle so a request coincident with done is ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         result <= '0;
         c_out  <= 1'b0;
         zero   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         count  <= '0;
         carry  <= 1'b0;
         sh_a   <= '0;
         sh_b   <= '0;
         l_reg  <= 1'b0;
         s_reg  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !done) begin
                  sh_a   <= a;
                  sh_b   <= b;
                  l_reg  <= l;
                  s_reg  <= s;
                  carry  <= c_in;
                  count  <= '0;
                  result <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               result <= {cell_out, result[WIDTH-1:1]};
               carry  <= cell_c_out;
               sh_a   <= sh_a >> 1;
               sh_b   <= sh_b >> 1;
               count  <= count + 1'b1;
               if (count == LAST) begin
                  busy  <= 1'b0;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b1;
               c_out <= l_reg ? 1'b0 : carry;
               zero  <= (result == '0);
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_serie.sv
// Self-checking bench for alu_serie (WIDTH=8): directed vector table, random
// operations against a word-level model, and hand-written multi-cycle sequences.
module tb_alu_serie;

   localparam int W = 8;
   localparam int LAT = W + 1;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         l;
   logic [1:0]   s;
   logic         c_in;
   logic [W-1:0] result;
   logic         c_out;
   logic         zero;
   logic         busy;
   logic         done;

   int checks = 0;
   int errors = 0;

   alu_serie #(.WIDTH(W)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .a      (a),
      .b      (b),
      .l      (l),
      .s      (s),
      .c_in   (c_in),
      .result (result),
      .c_out  (c_out),
      .zero   (zero),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         l;
      logic [1:0]   s;
      logic         c_in;
      logic [W-1:0] res;
      logic         co;
      logic         z;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Word-level reference: modular add with carry, or whole-word logic function
   task automatic model(input logic [W-1:0] ma, mb, input logic ml, input logic [1:0] ms,
                        input logic mc, output logic [W-1:0] mr, output logic mco, output logic mz);
      logic [W:0] sum;
      if (!ml) begin
         sum = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
         mr  = sum[W-1:0];
         mco = sum[W];
      end else begin
         case (ms)
            2'b00:   mr = ma & mb;
            2'b01:   mr = ma | mb;
            2'b10:   mr = ma ^ mb;
            default: mr = ~(ma ^ mb);
         endcase
         mco = 1'b0;
      end
      mz = (mr == '0);
   endtask

   // Issue one start pulse, scramble inputs while running, and check outputs at done
   task automatic run_op(input string tag, input logic [W-1:0] ia, ib, input logic il,
                         input logic [1:0] is, input logic ic,
                         input logic [W-1:0] er, input logic eco, input logic ez);
      int lat;
      @(negedge clk);
      a = ia; b = ib; l = il; s = is; c_in = ic; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy"}, {31'b0, busy}, 32'd1);
      lat = 0;
      while (!done && lat < 40) begin
         a = W'($urandom); b = W'($urandom); l = ~l; s = 2'($urandom); c_in = ~c_in;
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, lat, LAT);
      check({tag, "_result"}, {24'b0, result}, {24'b0, er});
      check({tag, "_c_out"}, {31'b0, c_out}, {31'b0, eco});
      check({tag, "_zero"}, {31'b0, zero}, {31'b0, ez});
      @(negedge clk);
      check({tag, "_done_width"}, {31'b0, done}, 32'd0);
   endtask

   // Watch n cycles and return how many done pulses were seen
   task automatic count_done(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (done) cnt++;
      end
   endtask

   initial begin
      logic [W-1:0] ra, rb, mr;
      logic         rl, rc, mco, mz;
      logic [1:0]   rs;
      int           nd;

      vecs.push_back('{8'h5A, 8'h33, 1'b0, 2'd0, 1'b0, 8'h8D, 1'b0, 1'b0});
      vecs.push_back('{8'hFF, 8'h01, 1'b0, 2'd0, 1'b0, 8'h00, 1'b1, 1'b1});
      vecs.push_back('{8'h10, 8'h20, 1'b0, 2'd0, 1'b1, 8'h31, 1'b0, 1'b0});
      vecs.push_back('{8'hC5, 8'h3A, 1'b1, 2'd0, 1'b0, 8'h00, 1'b0, 1'b1});
      vecs.push_back('{8'hC5, 8'h3A, 1'b1, 2'd1, 1'b0, 8'hFF, 1'b0, 1'b0});
      vecs.push_back('{8'hC5, 8'h3A, 1'b1, 2'd2, 1'b0, 8'hFF, 1'b0, 1'b0});
      vecs.push_back('{8'hC5, 8'h3A, 1'b1, 2'd3, 1'b0, 8'h00, 1'b0, 1'b1});
      vecs.push_back('{8'hFF, 8'hFF, 1'b1, 2'd0, 1'b1, 8'hFF, 1'b0, 1'b0});
      vecs.push_back('{8'h80, 8'h80, 1'b0, 2'd0, 1'b0, 8'h00, 1'b1, 1'b1});

      reset = 1'b1; start = 1'b0; a = '0; b = '0; l = 1'b0; s = '0; c_in = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_result", {24'b0, result}, 32'd0);
      check("rst_flags", {28'b0, c_out, zero, busy, done}, 32'd0);

      // Directed table
      foreach (vecs[i])
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].l, vecs[i].s,
                vecs[i].c_in, vecs[i].res, vecs[i].co, vecs[i].z);

      // Random operations against the word-level model
      for (int i = 0; i < 40; i++) begin
         ra = W'($urandom); rb = W'($urandom); rl = 1'($urandom); rs = 2'($urandom);
         rc = 1'($urandom);
         if (i % 8 == 0) rb = ~ra;
         model(ra, rb, rl, rs, rc, mr, mco, mz);
         run_op($sformatf("rnd%0d", i), ra, rb, rl, rs, rc, mr, mco, mz);
      end

      // start held high through RUN with changing operands: one op of the first operands
      @(negedge clk);
      a = 8'h12; b = 8'h34; l = 1'b0; s = 2'd0; c_in = 1'b0; start = 1'b1;
      nd = 0;
      for (int i = 0; i < 40 && nd == 0; i++) begin
         @(negedge clk);
         if (done) nd++;
         else begin a = W'($urandom); b = W'($urandom); end
      end
      start = 1'b0;
      check("hold_done_seen", nd, 1);
      check("hold_result", {24'b0, result}, 32'h46);
      count_done(15, nd);
      check("hold_no_extra_done", nd, 0);
      check("hold_idle", {31'b0, busy}, 32'd0);

      // start pulse coincident with done is ignored
      @(negedge clk);
      a = 8'h01; b = 8'h02; l = 1'b0; c_in = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      nd = 0;
      for (int i = 0; i < 40 && !done; i++) @(negedge clk);
      check("dc_done", {31'b0, done}, 32'd1);
      a = 8'h77; b = 8'h11; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("dc_not_busy", {31'b0, busy}, 32'd0);
      count_done(15, nd);
      check("dc_no_done", nd, 0);
      check("dc_result_held", {24'b0, result}, 32'h03);

      // Leave c_out/zero set, then reset mid-RUN
      run_op("pre_rst", 8'hFF, 8'h01, 1'b0, 2'd0, 1'b0, 8'h00, 1'b1, 1'b1);
      @(negedge clk);
      a = 8'h5A; b = 8'h33; l = 1'b0; c_in = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("mid_busy", {31'b0, busy}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mrst_busy", {31'b0, busy}, 32'd0);
      check("mrst_result", {24'b0, result}, 32'd0);
      check("mrst_flags", {29'b0, c_out, zero, done}, 32'd0);
      count_done(15, nd);
      check("mrst_no_done", nd, 0);
      run_op("post_rst", 8'h01, 8'h01, 1'b0, 2'd0, 1'b0, 8'h02, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
